div_unit: RTL and testbench
===========================

# div_unit

Serial RV32M divider sitting directly downstream of the dispatcher's DIV port. It accepts one DIV/DIVU/REM/REMU operation per `dispatcher_div_inf_t` transfer and computes it with a multi-cycle restoring shift-subtract loop. It pulses `div_done` to release the dispatcher's `div_stall`, and presents the result on a single-cycle write-back port.

## Interface
Parameters:
- `DATA_WIDTH`, 32: operand/result width; also the iteration count.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  core flush; aborts any in-flight op.
- `dispatcher_div_inf`  in  `dispatcher_div_inf_t`  fields `ctrl.instruction_valid`, `ctrl.div_control`, `rd`, `rs1`, `rs2`.
- `div_done`  out  1  one-cycle pulse when a result is presented.
- `div_busy`  out  1  high in any state other than IDLE.
- `wb_valid`  out  1  write-back request, one cycle.
- `wb_rd`  out  5  destination register.
- `wb_data`  out  `DATA_WIDTH`  quotient or remainder.

## Operation
- States are IDLE, BUSY, DONE. Reset enters IDLE.
- IDLE with `instruction_valid & ~flush`:
  - Latch `rd` and `div_control`.
  - Compute `sign_a = rs1[MSB] & signed_op` and `sign_b = rs2[MSB] & signed_op`. `signed_op` is true for DIV and REM.
  - Latch the magnitudes |rs1| and |rs2|.
- Special cases are detected at accept and go straight to DONE, skipping BUSY:
  - Divisor zero: quotient = all-ones, remainder = rs1 unchanged, for both signed and unsigned ops.
  - Signed overflow (rs1 = 0x8000_0000, rs2 = all-ones, DIV/REM): quotient = 0x8000_0000, remainder = 0.
- Otherwise go to BUSY with iteration counter = 0.
- BUSY, each cycle:
  - `{rem, quo} <<= 1`.
  - If the shifted rem ≥ divisor: rem −= divisor and quo[0] = 1.
  - Counter += 1. At counter == `DATA_WIDTH`−1 (the last step), go to DONE.
  - The subtract is `DATA_WIDTH`+1 bits wide; no truncation.
- Sign fix-up is applied when entering DONE:
  - Quotient is negated if `sign_a ^ sign_b`.
  - Remainder is negated if `sign_a` (remainder takes the dividend's sign).
- DONE, for one cycle: `div_done`=1; `wb_data` = quotient for DIV/DIVU, remainder for REM/REMU. Then go to IDLE.
- `wb_valid = div_done & (wb_rd != 0)`. x0 is never written, but `div_done` still pulses.
- `instruction_valid` is ignored outside IDLE; the dispatcher holds off issue while `div_stall` is set.
- `flush` in any state: go to IDLE next cycle, with no `div_done` and no `wb_valid`. Flush has priority over accept and over DONE.
- `rst` mid-operation: same effect as flush.

## Timing
- Accept at edge N (IDLE, valid sampled).
- Normal path: BUSY during cycles N+1..N+`DATA_WIDTH`; DONE at cycle N+`DATA_WIDTH`+1 (N+33 for 32 bits).
- Special-case path: DONE at cycle N+1.
- Back-to-back: a new accept is allowed in the first IDLE cycle after DONE. Issue-to-issue minimum is 34 cycles on the normal path.
- All outputs are registered.
- Reset values: `div_done`=0, `wb_valid`=0, `div_busy`=0, `wb_rd`=0, `wb_data`=0.
- `wb_rd` and `wb_data` hold their values outside DONE and are not cleared.
- Flush arriving in the same cycle as DONE suppresses that cycle's `div_done`/`wb_valid`. This requires a combinational gate on the registered pulse: `div_done_q & ~flush`.

## Structure
- The shared defines package holds:
  - `div_op_t` (`DIV_OP_DIV`, `DIV_OP_DIVU`, `DIV_OP_REM`, `DIV_OP_REMU`).
  - `dispatcher_div_inf_t`.
  - A new `div_wb_inf_t` bundling `wb_valid`/`wb_rd`/`wb_data` for the WB arbiter.
  - `LATENCY_DIV_OP` = `DATA_WIDTH`+1.
- The state enum is local to the module.
- One sub-module, `div_iter_core`: the unsigned shift-subtract datapath (rem/quo/divisor registers, counter, `last` flag). The parent keeps the FSM, special-case detection and sign fix-up.

## Test plan
- DIVU 100 / 7 accepted at N → `div_done`=1 at exactly N+33 for one cycle, `wb_data`=14, `wb_rd` equal to the latched rd.
- REM −7 % 2 → `wb_data`=0xFFFF_FFFF; DIV −7 / 2 → 0xFFFF_FFFD (−3).
- DIV 5 / 0 → `wb_data`=0xFFFF_FFFF at N+1; REMU 5 / 0 → 5 at N+1.
- DIV 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000 at N+1; the REM form → 0.
- `flush` at N+10 → no `div_done` in the following 40 cycles, `div_busy`=0 at N+11; an op accepted at N+11 completes at N+44.
- rd=x0, DIVU 9 / 3 → `div_done`=1 and `wb_valid`=0 at N+33. Separately, `rst` at N+5 → all outputs 0 and state IDLE at N+6.

Source files
------------

// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared types and constants for the serial RV32M divider
package div_unit_pkg;

  localparam int XLEN = 32;
  localparam int LATENCY_DIV_OP = XLEN + 1;

  typedef enum logic [1:0] {
    DIV_OP_DIV,
    DIV_OP_DIVU,
    DIV_OP_REM,
    DIV_OP_REMU
  } div_op_t;

  typedef struct packed {
    logic    instruction_valid;
    div_op_t div_control;
  } div_ctrl_t;

  typedef struct packed {
    div_ctrl_t         ctrl;
    logic [4:0]        rd;
    logic [XLEN-1:0]   rs1;
    logic [XLEN-1:0]   rs2;
  } dispatcher_div_inf_t;

  typedef struct packed {
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
  } div_wb_inf_t;

  function automatic logic op_is_signed(input div_op_t op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  function automatic logic op_is_rem(input div_op_t op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

endpackage

// File: rtl/div_iter_core.sv
// rtl/div_iter_core.sv - unsigned restoring shift-subtract datapath, one quotient bit per cycle
module div_iter_core #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         kill,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quo_next,
  output logic [W-1:0] rem_next,
  output logic         last
);

  localparam int CNT_W = $clog2(W);

  logic [W-1:0]     rem_q, rem_d;
  logic [W-1:0]     quo_q, quo_d;
  logic [W-1:0]     dsr_q, dsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic [W:0]       shifted;
  logic [W:0]       diff;
  logic             ge;

  always_comb begin
    // A borrow out of the W+1 bit subtract means the shifted remainder is below the divisor.
    shifted  = {rem_q, quo_q[W-1]};
    diff     = shifted - {1'b0, dsr_q};
    ge       = ~diff[W];
    rem_next = ge ? diff[W-1:0] : shifted[W-1:0];
    quo_next = {quo_q[W-2:0], ge};
    last     = run_q && (cnt_q == CNT_W'(W - 1));

    rem_d = rem_q;
    quo_d = quo_q;
    dsr_d = dsr_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (kill) begin
      run_d = 1'b0;
    end else if (start) begin
      rem_d = '0;
      quo_d = dividend;
      dsr_d = divisor;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      rem_d = rem_next;
      quo_d = quo_next;
      cnt_d = cnt_q + CNT_W'(1);
      if (last) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dsr_q <= dsr_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - DIV/DIVU/REM/REMU unit: accept, special cases, sign fix-up and write-back
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  dispatcher_div_inf_t   dispatcher_div_inf,
  output logic                  div_done,
  output logic                  div_busy,
  output logic                  wb_valid,
  output logic [4:0]            wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data
);

  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [4:0]            rd_q, rd_d;
  div_op_t               op_q, op_d;
  logic                  sign_a_q, sign_a_d;
  logic                  sign_b_q, sign_b_d;
  logic                  done_q, done_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic [4:0]            wb_rd_q, wb_rd_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;

  logic [DATA_WIDTH-1:0] rs1, rs2, abs_a, abs_b;
  logic [DATA_WIDTH-1:0] core_quo, core_rem, quo_fix, rem_fix;
  logic                  in_signed, in_sign_a, in_sign_b, div_zero, overflow;
  logic                  core_start, core_last;

  assign rs1       = dispatcher_div_inf.rs1;
  assign rs2       = dispatcher_div_inf.rs2;
  assign in_signed = op_is_signed(dispatcher_div_inf.ctrl.div_control);
  assign in_sign_a = rs1[DATA_WIDTH-1] & in_signed;
  assign in_sign_b = rs2[DATA_WIDTH-1] & in_signed;
  assign abs_a     = in_sign_a ? -rs1 : rs1;
  assign abs_b     = in_sign_b ? -rs2 : rs2;
  assign div_zero  = (rs2 == '0);
  assign overflow  = in_signed && (rs1 == MIN_NEG) && (rs2 == '1);
  assign quo_fix   = (sign_a_q ^ sign_b_q) ? -core_quo : core_quo;
  assign rem_fix   = sign_a_q ? -core_rem : core_rem;

  div_iter_core #(
    .W(DATA_WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .kill     (flush),
    .start    (core_start),
    .dividend (abs_a),
    .divisor  (abs_b),
    .quo_next (core_quo),
    .rem_next (core_rem),
    .last     (core_last)
  );

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    op_d       = op_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    done_d     = 1'b0;
    core_start = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (dispatcher_div_inf.ctrl.instruction_valid) begin
            rd_d     = dispatcher_div_inf.rd;
            op_d     = dispatcher_div_inf.ctrl.div_control;
            sign_a_d = in_sign_a;
            sign_b_d = in_sign_b;
            if (div_zero || overflow) begin
              // Divide-by-zero keeps the raw dividend as remainder; overflow yields MIN / 0.
              state_d   = S_DONE;
              done_d    = 1'b1;
              wb_rd_d   = dispatcher_div_inf.rd;
              if (op_is_rem(dispatcher_div_inf.ctrl.div_control))
                wb_data_d = div_zero ? rs1 : '0;
              else
                wb_data_d = div_zero ? '1 : MIN_NEG;
            end else begin
              state_d    = S_BUSY;
              core_start = 1'b1;
            end
          end
        end
        S_BUSY: begin
          if (core_last) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            wb_rd_d   = rd_q;
            wb_data_d = op_is_rem(op_q) ? rem_fix : quo_fix;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    valid_d = done_d && (wb_rd_d != 5'd0);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rd_q      <= '0;
      op_q      <= DIV_OP_DIV;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      op_q      <= op_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  // A flush landing in the DONE cycle must still cancel the already-registered pulse.
  assign div_done = done_q & ~flush;
  assign wb_valid = valid_q & ~flush;
  assign div_busy = busy_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit against an arithmetic reference model
module tb_div_unit;
  import div_unit_pkg::*;

  logic                clk;
  logic                rst;
  logic                flush;
  dispatcher_div_inf_t inf;
  logic                div_done, div_busy, wb_valid;
  logic [4:0]          wb_rd;
  logic [31:0]         wb_data;

  int n_checks = 0;
  int n_fail   = 0;

  div_unit #(.DATA_WIDTH(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .flush              (flush),
    .dispatcher_div_inf (inf),
    .div_done           (div_done),
    .div_busy           (div_busy),
    .wb_valid           (wb_valid),
    .wb_rd              (wb_rd),
    .wb_data            (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model(input div_op_t op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output int lat);
    logic        sgn;
    logic [31:0] q, r;
    sgn = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; lat = 0;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; lat = 0;
    end else begin
      lat = 32;
      if (sgn) begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end else begin
        q = a / b;
        r = a % b;
      end
    end
    res = (op == DIV_OP_REM || op == DIV_OP_REMU) ? r : q;
  endfunction

  // Caller is positioned just after a rising edge; the op is accepted on the next edge (offset 0).
  task automatic start_op(input div_op_t op, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
    inf.ctrl.instruction_valid = 1'b1;
    inf.ctrl.div_control       = op;
    inf.rd                     = rd;
    inf.rs1                    = a;
    inf.rs2                    = b;
    @(posedge clk); #1;
    inf.ctrl.instruction_valid = 1'b0;
  endtask

  task automatic do_op(input div_op_t op, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                       input string name);
    logic [31:0] exp;
    int          lat, seen, pulses;
    model(op, a, b, exp, lat);
    start_op(op, rd, a, b);
    seen = -1; pulses = 0;
    for (int k = 0; k <= lat + 1; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (div_done) begin
        pulses++;
        if (seen < 0) seen = k;
      end
      if (k == lat) begin
        n_checks += 4;
        if (wb_data !== exp) begin
          n_fail++; $display("FAIL %s wb_data got %h want %h", name, wb_data, exp);
        end
        if (wb_rd !== rd) begin
          n_fail++; $display("FAIL %s wb_rd got %0d want %0d", name, wb_rd, rd);
        end
        if (wb_valid !== (rd != 5'd0)) begin
          n_fail++; $display("FAIL %s wb_valid got %b want %b", name, wb_valid, rd != 5'd0);
        end
        if (div_busy !== 1'b1) begin
          n_fail++; $display("FAIL %s busy_in_done got %b want 1", name, div_busy);
        end
      end
    end
    n_checks += 3;
    if (seen != lat) begin
      n_fail++; $display("FAIL %s done_offset got %0d want %0d", name, seen, lat);
    end
    if (pulses != 1) begin
      n_fail++; $display("FAIL %s done_pulses got %0d want 1", name, pulses);
    end
    if (div_busy !== 1'b0) begin
      n_fail++; $display("FAIL %s busy_after got %b want 0", name, div_busy);
    end
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    n_checks += 5;
    if (div_done !== 1'b0) begin n_fail++; $display("FAIL reset div_done got %b want 0", div_done); end
    if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset wb_valid got %b want 0", wb_valid); end
    if (div_busy !== 1'b0) begin n_fail++; $display("FAIL reset div_busy got %b want 0", div_busy); end
    if (wb_rd !== 5'd0)    begin n_fail++; $display("FAIL reset wb_rd got %0d want 0", wb_rd); end
    if (wb_data !== 32'd0) begin n_fail++; $display("FAIL reset wb_data got %h want 0", wb_data); end
  endtask

  task automatic test_directed();
    do_op(DIV_OP_DIVU, 5'd7, 32'd100, 32'd7, "divu_100_7");
    do_op(DIV_OP_REM, 5'd3, -32'd7, 32'd2, "rem_m7_2");
    do_op(DIV_OP_DIV, 5'd4, -32'd7, 32'd2, "div_m7_2");
    do_op(DIV_OP_DIV, 5'd5, 32'd5, 32'd0, "div_5_0");
    do_op(DIV_OP_REMU, 5'd6, 32'd5, 32'd0, "remu_5_0");
    do_op(DIV_OP_REM, 5'd8, -32'd5, 32'd0, "rem_m5_0");
    do_op(DIV_OP_DIV, 5'd9, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    do_op(DIV_OP_REM, 5'd10, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    do_op(DIV_OP_DIVU, 5'd11, 32'h8000_0000, 32'hFFFF_FFFF, "divu_no_ovf");
    do_op(DIV_OP_DIVU, 5'd0, 32'd9, 32'd3, "divu_x0");
    do_op(DIV_OP_DIVU, 5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "divu_max");
  endtask

  task automatic test_flush();
    int late;
    start_op(DIV_OP_DIVU, 5'd13, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_checks += 2;
    if (div_busy !== 1'b0) begin n_fail++; $display("FAIL flush busy got %b want 0", div_busy); end
    if (div_done !== 1'b0) begin n_fail++; $display("FAIL flush done got %b want 0", div_done); end
    do_op(DIV_OP_DIV, 5'd14, -32'd100, 32'd9, "after_flush");
    // Flush raised inside the DONE cycle cancels the visible pulse.
    start_op(DIV_OP_DIVU, 5'd15, 32'd77, 32'd5);
    repeat (32) @(posedge clk);
    #1;
    n_checks += 1;
    if (div_done !== 1'b1) begin n_fail++; $display("FAIL late_flush pre_done got %b want 1", div_done); end
    flush = 1'b1;
    #1;
    n_checks += 2;
    if (div_done !== 1'b0) begin n_fail++; $display("FAIL late_flush done got %b want 0", div_done); end
    if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL late_flush wb_valid got %b want 0", wb_valid); end
    @(posedge clk); #1;
    flush = 1'b0;
    late = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (div_done) late++;
    end
    n_checks += 1;
    if (late != 0) begin n_fail++; $display("FAIL late_flush stray_done got %0d want 0", late); end
  endtask

  task automatic test_rst_mid();
    int stray;
    start_op(DIV_OP_DIVU, 5'd17, 32'd123456, 32'd7);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    test_reset();
    stray = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (div_done || div_busy) stray++;
    end
    n_checks += 1;
    if (stray != 0) begin n_fail++; $display("FAIL rst_mid activity got %0d want 0", stray); end
    do_op(DIV_OP_REMU, 5'd18, 32'd123456, 32'd7, "after_rst");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      do_op(div_op_t'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), rand_operand(), rand_operand(), "random");
    end
  endtask

  task automatic test_back_to_back();
    do_op(DIV_OP_DIV, 5'd20, 32'd50, -32'd7, "b2b_a");
    do_op(DIV_OP_REM, 5'd21, 32'd50, -32'd7, "b2b_b");
    do_op(DIV_OP_DIVU, 5'd22, 32'd8, 32'd0, "b2b_c");
    do_op(DIV_OP_REMU, 5'd23, 32'hDEAD_BEEF, 32'h1234, "b2b_d");
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    inf   = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_flush();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
